// File: rtl/frontend_queue_if.sv
// frontend_queue_if: fetch-to-decode bundle between the stage-2 fetch register and the frontend queue
//   in_bubble/in_pc/in_slot_id/in_exc/in_instr : incoming fetch (driven by master)
//   deq                                        : decode consumes head (driven by master)
//   out_valid/out_pc/out_slot_id/out_exc/out_instr : head entry (driven by slave)
interface frontend_queue_if;
  logic        in_bubble;
  logic [31:0] in_pc;
  logic [31:0] in_slot_id;
  logic [7:0]  in_exc;
  logic [31:0] in_instr;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_slot_id;
  logic [7:0]  out_exc;
  logic [31:0] out_instr;
  modport master (
    output in_bubble, in_pc, in_slot_id, in_exc, in_instr, deq,
    input  out_valid, out_pc, out_slot_id, out_exc, out_instr
  );
  modport slave (
    input  in_bubble, in_pc, in_slot_id, in_exc, in_instr, deq,
    output out_valid, out_pc, out_slot_id, out_exc, out_instr
  );
endinterface

// File: rtl/frontend_queue.sv
// frontend_queue: circular FIFO between stage-2 fetch and decode, with issue-stop stall and redirect flush
//   clk, rst (async, active-high), clk_en (global hold), flush (redirect)
//   q         : fetch/decode bundle (slave side)
//   stall_out : registered issue-stop, count_next >= DEPTH-SKID
//   count     : occupancy 0..DEPTH
//   overflow  : sticky, a push was dropped at full
//   order_err : only with FRONTEND_QUEUE_ORDER_CHECK_EN defined; one-cycle pulse on a non-consecutive slot id
module frontend_queue #(
  parameter int DEPTH = 8,
  parameter int SKID  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic                       flush,
  frontend_queue_if.slave            q,
  output logic                       stall_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
`ifdef FRONTEND_QUEUE_ORDER_CHECK_EN
  ,
  output logic                       order_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [103:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [103:0]  head;
  logic          pop, push, drop;
  logic [CW-1:0] count_next;
  // A pop at full frees the slot on the same edge, so push is still accepted.
  always_comb begin
    pop        = !flush && q.deq && q.out_valid;
    push       = !flush && !q.in_bubble && (count < CW'(DEPTH) || pop);
    drop       = !flush && !q.in_bubble && count == CW'(DEPTH) && !pop;
    count_next = flush ? '0 : count + CW'(push) - CW'(pop);
  end
  assign q.out_valid = count != '0;
  assign head = q.out_valid ? mem[rd_ptr] : '0;
  assign {q.out_pc, q.out_slot_id, q.out_exc, q.out_instr} = head;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stall_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (clk_en) begin
      rd_ptr    <= flush ? '0 : rd_ptr + AW'(pop);
      wr_ptr    <= flush ? '0 : wr_ptr + AW'(push);
      count     <= count_next;
      stall_out <= count_next >= CW'(DEPTH - SKID);
      overflow  <= overflow | drop;
    end
  end
  always_ff @(posedge clk) begin
    if (clk_en && push) mem[wr_ptr] <= {q.in_pc, q.in_slot_id, q.in_exc, q.in_instr};
  end
`ifdef FRONTEND_QUEUE_ORDER_CHECK_EN
  logic [31:0] last_slot;
  logic        have_last;
  // Slot ids stay monotonic across redirects, so flush leaves the tracker alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_slot <= '0;
      have_last <= 1'b0;
      order_err <= 1'b0;
    end else if (clk_en) begin
      order_err <= push && have_last && q.in_slot_id != last_slot + 32'd1;
      if (push) begin
        last_slot <= q.in_slot_id;
        have_last <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_frontend_queue.sv
// tb_frontend_queue: table-driven directed check of frontend_queue plus reset and order-check sequences
module tb_frontend_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       flush = 1'b0;
  logic       stall_out;
  logic [3:0] count;
  logic       overflow;
`ifdef FRONTEND_QUEUE_ORDER_CHECK_EN
  logic       order_err;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  frontend_queue_if q ();
  frontend_queue dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .flush(flush),
    .q(q.slave),
    .stall_out(stall_out),
    .count(count),
    .overflow(overflow)
`ifdef FRONTEND_QUEUE_ORDER_CHECK_EN
    ,
    .order_err(order_err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        ce, fl, bub, deq;
    logic [31:0] pc;
    logic [7:0]  exc;
    logic [3:0]  cnt;
    logic        val;
    logic [31:0] hpc;
    logic [7:0]  hexc;
    logic        stall, ovf;
  } vec_t;
  vec_t v[$];
  task automatic add(input logic ce, fl, bub, deq, input logic [31:0] pc, input logic [7:0] exc,
                     input logic [3:0] cnt, input logic val, input logic [31:0] hpc,
                     input logic [7:0] hexc, input logic stall, ovf);
    vec_t t;
    t.ce = ce; t.fl = fl; t.bub = bub; t.deq = deq; t.pc = pc; t.exc = exc;
    t.cnt = cnt; t.val = val; t.hpc = hpc; t.hexc = hexc; t.stall = stall; t.ovf = ovf;
    v.push_back(t);
  endtask
  task automatic chk(input string name, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic ce, fl, bub, deq, input logic [31:0] pc, slot, input logic [7:0] exc);
    clk_en = ce; flush = fl; q.in_bubble = bub; q.deq = deq;
    q.in_pc = pc; q.in_slot_id = slot; q.in_exc = exc; q.in_instr = ~pc;
  endtask
  task automatic check_all(input string tag, input logic [3:0] cnt, input logic val,
                           input logic [31:0] hpc, input logic [7:0] hexc, input logic stall, ovf);
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " out_valid"}, 32'(q.out_valid), 32'(val));
    chk({tag, " out_pc"}, q.out_pc, hpc);
    chk({tag, " out_slot_id"}, q.out_slot_id, hpc);
    chk({tag, " out_instr"}, q.out_instr, val ? ~hpc : 32'h0);
    chk({tag, " out_exc"}, 32'(q.out_exc), 32'(hexc));
    chk({tag, " stall_out"}, 32'(stall_out), 32'(stall));
    chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
  endtask
  initial begin
    for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 32'h400 + 4 * i, 0, 4'(i + 1), 1, 32'h400, 0, (i + 1) >= 5, 0);
    for (int j = 1; j <= 8; j++) add(1, 0, 1, 1, 0, 0, 4'(8 - j), j < 8, j < 8 ? 32'h400 + 4 * j : 0, 0, (8 - j) >= 5, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 32'h400 + 4 * i, 0, 4'(i + 1), 1, 32'h400, 0, (i + 1) >= 5, 0);
    add(1, 0, 0, 1, 32'h500, 0, 8, 1, 32'h404, 0, 1, 0);
    for (int j = 1; j <= 7; j++) add(1, 0, 1, 1, 0, 0, 4'(8 - j), 1, j < 7 ? 32'h404 + 4 * j : 32'h500, 0, (8 - j) >= 5, 0);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 32'h700 + 4 * i, 0, 4'(i + 2), 1, 32'h500, 0, (i + 2) >= 5, 0);
    add(1, 0, 0, 0, 32'h600, 0, 8, 1, 32'h500, 0, 1, 1);
    for (int j = 1; j <= 4; j++) add(1, 0, 1, 1, 0, 0, 4'(8 - j), 1, 32'h700 + 4 * (j - 1), 0, (8 - j) >= 5, 1);
    add(1, 1, 0, 1, 32'h800, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h900, 0, 1, 1, 32'h900, 0, 0, 1);
    add(0, 0, 0, 1, 32'hA00, 8'h84, 1, 1, 32'h900, 0, 0, 1);
    add(1, 0, 0, 1, 32'hA00, 8'h84, 1, 1, 32'hA00, 8'h84, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    foreach (v[k]) begin
      drive(v[k].ce, v[k].fl, v[k].bub, v[k].deq, v[k].pc, v[k].pc, v[k].exc);
      @(posedge clk);
      #1 check_all($sformatf("vec%0d", k), v[k].cnt, v[k].val, v[k].hpc, v[k].hexc, v[k].stall, v[k].ovf);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 32'hB00 + 4 * i, 32'hB00 + 4 * i, 0);
      @(posedge clk);
      #1;
    end
    chk("midfill count", 32'(count), 32'd4);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef FRONTEND_QUEUE_ORDER_CHECK_EN
    begin
      logic [31:0] ids [3];
      logic        exp_err [3];
      ids = '{32'd5, 32'd6, 32'd8};
      exp_err = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
        drive(1, 0, 0, 0, 32'hC00 + 4 * i, ids[i], 0);
        @(posedge clk);
        #1 chk($sformatf("order_err push%0d", i), 32'(order_err), 32'(exp_err[i]));
      end
      drive(1, 0, 1, 0, 0, 0, 0);
      @(posedge clk);
      #1 chk("order_err idle", 32'(order_err), 32'd0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
